tx_mii_framer: RTL
==================

Name: tx_mii_framer

Overview:
- Parametrised successor to the fixed 1G encap+GMII transmit pair.
- Pops 64-bit words from a first-word-fall-through TX FIFO. Each packet is a header word followed by payload words.
- Emits preamble/SFD, then the payload serialized to an OUT_W-bit MII-style bus. Enforces a programmable inter-frame gap and honours received PAUSE quanta.
- Keeps packet/byte statistics. Sits between the TX FIFO and the PHY-side interface in tcore.

Parameters:
- OUT_W, 8, output data width in bits; legal values 8, 16, 32, 64. BPB = OUT_W/8 bytes per beat.
- MAX_LEN, 9600, largest accepted frame byte count. Frame includes FCS, which is supplied upstream.
- MIN_LEN, 8, smallest accepted frame byte count.

Ports:
- x_clk  in  1  sole clock
- usr_rst_  in  1  asynchronous active-low reset
- tx_ifg_bytes  in  6  minimum inter-frame gap in bytes; values below 12 are treated as 12
- txfifo_dout  in  64  FWFT data. Header word: [15:0] = frame byte count. Payload: byte n at [8*(n%8)+7 : 8*(n%8)].
- txfifo_empty  in  1  FIFO empty
- txfifo_rd_en  out  1  pop current word
- rx_pause  in  1  one-cycle pulse: PAUSE frame received
- rx_pvalue  in  16  pause quanta, valid with rx_pause
- rx_pack  out  1  one-cycle acknowledge of rx_pause
- txd  out  OUT_W  transmit data, byte 0 at [7:0]
- tx_en  out  1  frame (preamble through last byte) active
- tx_lane_vld  out  BPB  per-byte valid within the beat
- tx_err  out  1  one-cycle pulse: frame dropped for illegal length
- tx_paused  out  1  pause timer non-zero
- FMAC_TX_PKT_CNT  out  32  frames transmitted
- FMAC_TX_BYTE_CNT  out  32  frame bytes transmitted (preamble excluded)
- fmac_tx_clr_en  in  1  synchronous clear of both counters

Behaviour:
- Reset: all outputs 0, state IDLE, pause timer 0, counters 0.
- States: IDLE, PRE, DATA, IFG, DROP.
- IDLE:
  - If !txfifo_empty and pause timer == 0: pop the header (txfifo_rd_en=1) and latch len=[15:0].
  - If MIN_LEN <= len <= MAX_LEN, go to PRE; otherwise go to DROP.
  - Latency: header pop cycle N, first preamble beat on txd at N+1.
- PRE:
  - 8/BPB beats carrying bytes 55 55 55 55 55 55 55 D5.
  - tx_en=1 and tx_lane_vld all-ones throughout.
- DATA:
  - Serializes each payload word in 64/OUT_W beats.
  - txfifo_rd_en asserts on the beat that consumes the final byte of a word, or the final byte of the frame.
  - Last beat: tx_lane_vld = ((1<<r)-1), where r = len % BPB and r=0 means all ones. Invalid lanes drive 0.
  - If txfifo_empty while a word is needed (underrun), hold tx_en=1 with tx_lane_vld=0 until data arrives. No bytes are skipped.
  - After the last beat, go to IFG.
- IFG:
  - tx_en=0, txd=0.
  - Lasts ceil(max(tx_ifg_bytes,12)/BPB) cycles, then goes to IDLE.
- DROP:
  - Pops ceil(len/8) words with tx_en=0, then goes to IDLE.
  - tx_err pulses in the cycle the header is popped.
  - len=0 pops nothing further.
- Pause:
  - On rx_pause, the timer loads rx_pvalue*(64/BPB) cycles (one quantum = 512 bit times). Timer width is 23 bits.
  - rx_pack pulses on the next cycle.
  - A new rx_pause during countdown reloads the timer. rx_pvalue=0 clears it.
  - The timer decrements every cycle while non-zero, in every state.
  - Pause only blocks frame start in IDLE. An in-flight frame always completes.
- Counters:
  - At the end of each transmitted frame: PKT_CNT += 1 and BYTE_CNT += len. Both wrap modulo 2^32. Dropped frames are not counted.
  - fmac_tx_clr_en in the same cycle as an increment: counter loads the increment amount (1 / len), not 0.
- Reset asserted mid-frame: outputs drop to 0 immediately. No FIFO resynchronisation is performed by this block.

Decomposition:
- Shared package tx_mac_pkg:
  - state enum {IDLE, PRE, DATA, IFG, DROP}.
  - PREAMBLE_SFD constant 64'hD555_5555_5555_5555.
  - QUANTUM_BYTES = 64.
  - MIN_IFG = 12.
- One sub-module: tx_stat_cnt. It holds the 32-bit pkt/byte counters and the clear-vs-increment rule, and is instantiated once.

Test Plan:
- OUT_W=8, len=64, ifg=12 -> 8 preamble beats, 64 data beats, 8 pops after the header, 12 idle cycles; PKT=1, BYTE=64.
- OUT_W=32, len=66 -> 2 preamble beats, 17 data beats; last tx_lane_vld=4'b0011.
- Header len=5 and header len=10000 -> tx_err pulse each time; 1 then 1250 words popped; tx_en stays 0; counters unchanged.
- rx_pause with pvalue=2 mid-frame (OUT_W=8) -> frame completes; rx_pack pulses next cycle; next frame is held until 128 cycles after the pause; second pause with pvalue=0 releases immediately.
- txfifo_empty forced high for 5 cycles mid-DATA -> tx_en held, tx_lane_vld=0 for 5 cycles; byte stream intact afterwards.
- fmac_tx_clr_en coincident with end-of-frame len=100 -> PKT=1, BYTE=100; clr alone -> both counters 0.

Source files
------------

// File: rtl/tx_mac_pkg.sv
// Shared definitions for the transmit MAC framer.
// Contents:
//   tx_state_e   - framer FSM states
//   PREAMBLE_SFD - preamble + SFD, byte 0 at [7:0]
//   QUANTUM_BYTES, MIN_IFG - pause quantum size and floor for the IFG setting
//   tail_mask()  - lane mask for the final beat of a frame
package tx_mac_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    IFG  = 3'd3,
    DROP = 3'd4
  } tx_state_e;

  localparam logic [63:0] PREAMBLE_SFD  = 64'hD555_5555_5555_5555;
  localparam int          QUANTUM_BYTES = 64;
  localparam int          MIN_IFG       = 12;

  // r = leftover bytes in the last beat; r == 0 means the beat is full.
  function automatic logic [7:0] tail_mask(input logic [2:0] r);
    return (r == 3'd0) ? 8'hFF : 8'((9'd1 << r) - 9'd1);
  endfunction

endpackage

// File: rtl/tx_stat_cnt.sv
// Transmit statistics: 32-bit frame and byte counters, both wrapping.
// Ports:
//   x_clk, usr_rst_ - clock, async active-low reset
//   i_clr           - synchronous clear of both counters
//   i_inc, i_len    - end of a transmitted frame and its byte count
//   o_pkt, o_byte   - counter values
// A clear coincident with an increment keeps that frame's contribution.
module tx_stat_cnt (
  input  logic        x_clk,
  input  logic        usr_rst_,
  input  logic        i_clr,
  input  logic        i_inc,
  input  logic [15:0] i_len,
  output logic [31:0] o_pkt,
  output logic [31:0] o_byte
);

  always_ff @(posedge x_clk or negedge usr_rst_) begin
    if (!usr_rst_) begin
      o_pkt  <= '0;
      o_byte <= '0;
    end else if (i_inc) begin
      o_pkt  <= i_clr ? 32'd1          : o_pkt + 32'd1;
      o_byte <= i_clr ? 32'(i_len)     : o_byte + 32'(i_len);
    end else if (i_clr) begin
      o_pkt  <= '0;
      o_byte <= '0;
    end
  end

endmodule

// File: rtl/tx_mii_framer.sv
// Transmit framer: pops header+payload words from an FWFT FIFO, emits
// preamble/SFD and the payload on an OUT_W-bit MII-style bus, enforces the
// inter-frame gap, honours PAUSE quanta and keeps tx statistics.
// Ports:
//   x_clk, usr_rst_          - clock, async active-low reset
//   tx_ifg_bytes             - IFG in bytes (floored at 12)
//   txfifo_dout/_empty/_rd_en- FWFT FIFO interface
//   rx_pause/rx_pvalue/rx_pack - pause request, quanta, acknowledge
//   txd/tx_en/tx_lane_vld    - PHY-side data, frame enable, byte lanes
//   tx_err                   - pulse on header of a dropped (bad length) frame
//   tx_paused                - pause timer running
//   FMAC_TX_PKT_CNT/BYTE_CNT, fmac_tx_clr_en - statistics and clear
module tx_mii_framer
  import tx_mac_pkg::*;
#(
  parameter int OUT_W   = 8,
  parameter int MAX_LEN = 9600,
  parameter int MIN_LEN = 8
) (
  input  logic               x_clk,
  input  logic               usr_rst_,
  input  logic [5:0]         tx_ifg_bytes,
  input  logic [63:0]        txfifo_dout,
  input  logic               txfifo_empty,
  output logic               txfifo_rd_en,
  input  logic               rx_pause,
  input  logic [15:0]        rx_pvalue,
  output logic               rx_pack,
  output logic [OUT_W-1:0]   txd,
  output logic               tx_en,
  output logic [OUT_W/8-1:0] tx_lane_vld,
  output logic               tx_err,
  output logic               tx_paused,
  output logic [31:0]        FMAC_TX_PKT_CNT,
  output logic [31:0]        FMAC_TX_BYTE_CNT,
  input  logic               fmac_tx_clr_en
);

  localparam int          BPB   = OUT_W / 8;
  localparam int          BSH   = $clog2(BPB);
  localparam int          QSH   = $clog2(QUANTUM_BYTES / BPB);
  localparam logic [15:0] BPB16 = 16'(BPB);

  tx_state_e   r_state;
  logic [15:0] r_len;
  logic [15:0] r_bcnt;   // byte offset: within preamble in PRE, within frame in DATA
  logic [15:0] r_cnt;    // IFG cycles or DROP words remaining
  logic [22:0] r_pause;
  logic        r_pack;

  logic             w_hdr_pop, w_hdr_ok, w_stall, w_last, w_wend, w_beat;
  logic [15:0]      w_rem, w_ifg_cyc;
  logic [5:0]       w_ifg;
  logic [7:0]       w_tail;
  logic [63:0]      w_src;
  logic [BPB-1:0]   w_lane;
  logic [OUT_W-1:0] w_bmask;

  assign w_hdr_pop = (r_state == IDLE) && !txfifo_empty && (r_pause == '0);
  assign w_hdr_ok  = (txfifo_dout[15:0] >= 16'(MIN_LEN)) &&
                     (txfifo_dout[15:0] <= 16'(MAX_LEN));
  // Underrun: hold the bus in-frame with no lanes valid until the FIFO refills.
  assign w_stall   = (r_state == DATA) && txfifo_empty;
  assign w_beat    = (r_state == DATA) && !w_stall;
  assign w_rem     = r_len - r_bcnt;
  assign w_last    = (w_rem <= BPB16);
  // This beat consumes byte 7 of the current 64-bit word.
  assign w_wend    = (4'(r_bcnt[2:0]) + 4'(BPB)) == 4'd8;
  assign w_tail    = tail_mask(r_len[2:0] & 3'(BPB - 1));

  assign w_ifg     = (tx_ifg_bytes < 6'(MIN_IFG)) ? 6'(MIN_IFG) : tx_ifg_bytes;
  assign w_ifg_cyc = (16'(w_ifg) + BPB16 - 16'd1) >> BSH;

  always_comb begin
    w_lane = '0;
    if (r_state == PRE)
      w_lane = '1;
    else if (w_beat)
      w_lane = w_last ? w_tail[BPB-1:0] : '1;
  end

  for (genvar gi = 0; gi < BPB; gi++) begin : g_bmask
    assign w_bmask[8*gi +: 8] = {8{w_lane[gi]}};
  end

  assign w_src = ((r_state == PRE) ? PREAMBLE_SFD : txfifo_dout) >> {r_bcnt[2:0], 3'b000};

  assign txd          = w_src[OUT_W-1:0] & w_bmask;
  assign tx_lane_vld  = w_lane;
  assign tx_en        = (r_state == PRE) || (r_state == DATA);
  // Gated by reset so nothing is popped or flagged while held in reset.
  assign txfifo_rd_en = usr_rst_ && (w_hdr_pop ||
                        (w_beat && (w_wend || w_last)) ||
                        ((r_state == DROP) && (r_cnt != '0) && !txfifo_empty));
  assign tx_err       = usr_rst_ && w_hdr_pop && !w_hdr_ok;
  assign tx_paused    = (r_pause != '0);
  assign rx_pack      = r_pack;

  always_ff @(posedge x_clk or negedge usr_rst_) begin
    if (!usr_rst_) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_bcnt  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hdr_pop) begin
          r_len   <= txfifo_dout[15:0];
          r_bcnt  <= '0;
          r_cnt   <= 16'((17'(txfifo_dout[15:0]) + 17'd7) >> 3);
          r_state <= w_hdr_ok ? PRE : DROP;
        end
        PRE: begin
          if (w_wend) begin
            r_bcnt  <= '0;
            r_state <= DATA;
          end else begin
            r_bcnt  <= r_bcnt + BPB16;
          end
        end
        DATA: if (w_beat) begin
          if (w_last) begin
            r_cnt   <= w_ifg_cyc - 16'd1;
            r_state <= IFG;
          end else begin
            r_bcnt  <= r_bcnt + BPB16;
          end
        end
        IFG: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 16'd1;
        end
        DROP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else if (!txfifo_empty) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pause timer: a new request reloads (pvalue 0 clears), otherwise count down.
  always_ff @(posedge x_clk or negedge usr_rst_) begin
    if (!usr_rst_) begin
      r_pause <= '0;
      r_pack  <= 1'b0;
    end else begin
      r_pack <= rx_pause;
      if (rx_pause)
        r_pause <= 23'(rx_pvalue) << QSH;
      else if (r_pause != '0)
        r_pause <= r_pause - 23'd1;
    end
  end

  tx_stat_cnt u_stat (
    .x_clk    (x_clk),
    .usr_rst_ (usr_rst_),
    .i_clr    (fmac_tx_clr_en),
    .i_inc    (w_beat && w_last),
    .i_len    (r_len),
    .o_pkt    (FMAC_TX_PKT_CNT),
    .o_byte   (FMAC_TX_BYTE_CNT)
  );

endmodule
